gpio_serial_loader: RTL and testbench

// - Transmit end of the user-area GPIO configuration chain: shifts one CFG_BITS word per pad into the

---
 rtl/gpio_serial_loader.sv | 168 ++++++++++++++++
 tb/tb_gpio_serial_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_serial_loader.sv
// Serial loader for the user-area GPIO configuration chains.
// Shifts one config word per pad into two parallel chains, then strobes serial_load to latch them.
module gpio_serial_loader #(
   parameter int NUM_IO    = 38,
   parameter int AREA1PADS = 19,
   parameter int CFG_BITS  = 13,
   parameter int CLK_DIV   = 2
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                xfer_start,
   output logic                busy,
   output logic                done,
   output logic [5:0]          cfg_addr_1,
   input  logic [CFG_BITS-1:0] cfg_data_1,
   output logic [5:0]          cfg_addr_2,
   input  logic [CFG_BITS-1:0] cfg_data_2,
   output logic                serial_clock,
   output logic                serial_load,
   output logic                serial_data_1,
   output logic                serial_data_2
);

   // state | meaning
   // IDLE  | waiting for xfer_start
   // FETCH | word 0 addresses on cfg_addr, data captured on exit
   // SHIFT | clocking words out MSB first, low phase then high phase per bit
   // LOAD  | serial_load high for CLK_DIV cycles
   // FIN   | done pulse, back to IDLE

   localparam int A2     = NUM_IO - AREA1PADS;
   localparam int W      = (AREA1PADS > A2) ? AREA1PADS : A2;
   localparam int FILL1  = W - AREA1PADS;
   localparam int FILL2  = W - A2;
   localparam int BIT_W  = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
   localparam int WORD_W = (W > 1) ? $clog2(W) : 1;
   localparam int PH_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CFG_BITS - 1);
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(W - 1);
   localparam logic [PH_W-1:0]   LAST_PH   = PH_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LOAD, FIN} state_t;

   state_t              state;
   logic [BIT_W-1:0]    bit_cnt;
   logic [WORD_W-1:0]   word_cnt;
   logic [PH_W-1:0]     ph_cnt;
   logic                high;
   logic [CFG_BITS-1:0] sr_1;
   logic [CFG_BITS-1:0] sr_2;

   int                  nxt_k;
   logic                nxt_real_1;
   logic                nxt_real_2;
   logic [5:0]          nxt_addr_1;
   logic [5:0]          nxt_addr_2;
   logic [CFG_BITS-1:0] nxt_word_1;
   logic [CFG_BITS-1:0] nxt_word_2;

   // The outgoing bit is always the MSB of the shift register, so data is cleared by clearing sr.
   assign serial_data_1 = sr_1[CFG_BITS-1];
   assign serial_data_2 = sr_2[CFG_BITS-1];

   // Chain 1 walks pads downward to pad 0, chain 2 upward to NUM_IO-1; leading words may be filler.
   always_comb begin
      nxt_k      = (state == SHIFT) ? int'(word_cnt) + 1 : 0;
      nxt_real_1 = (nxt_k >= FILL1);
      nxt_real_2 = (nxt_k >= FILL2);
      nxt_addr_1 = 6'(W - 1 - nxt_k);
      nxt_addr_2 = 6'(NUM_IO - W + nxt_k);
      nxt_word_1 = nxt_real_1 ? cfg_data_1 : '0;
      nxt_word_2 = nxt_real_2 ? cfg_data_2 : '0;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         serial_clock <= 1'b0;
         serial_load  <= 1'b0;
         cfg_addr_1   <= '0;
         cfg_addr_2   <= '0;
         sr_1         <= '0;
         sr_2         <= '0;
         bit_cnt      <= '0;
         word_cnt     <= '0;
         ph_cnt       <= '0;
         high         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (xfer_start) begin
                  state <= FETCH;
                  busy  <= 1'b1;
                  if (nxt_real_1) cfg_addr_1 <= nxt_addr_1;
                  if (nxt_real_2) cfg_addr_2 <= nxt_addr_2;
               end
            end
            FETCH: begin
               sr_1     <= nxt_word_1;
               sr_2     <= nxt_word_2;
               ph_cnt   <= '0;
               high     <= 1'b0;
               bit_cnt  <= '0;
               word_cnt <= '0;
               state    <= SHIFT;
            end
            SHIFT: begin
               if (ph_cnt != LAST_PH) begin
                  ph_cnt <= ph_cnt + 1'b1;
               end else begin
                  ph_cnt <= '0;
                  if (!high) begin
                     high         <= 1'b1;
                     serial_clock <= 1'b1;
                     // Present the next word's address one half-period before it is captured.
                     if (bit_cnt == LAST_BIT && word_cnt != LAST_WORD) begin
                        if (nxt_real_1) cfg_addr_1 <= nxt_addr_1;
                        if (nxt_real_2) cfg_addr_2 <= nxt_addr_2;
                     end
                  end else begin
                     high         <= 1'b0;
                     serial_clock <= 1'b0;
                     if (bit_cnt != LAST_BIT) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        sr_1    <= {sr_1[CFG_BITS-2:0], 1'b0};
                        sr_2    <= {sr_2[CFG_BITS-2:0], 1'b0};
                     end else begin
                        bit_cnt <= '0;
                        if (word_cnt == LAST_WORD) begin
                           word_cnt    <= '0;
                           sr_1        <= '0;
                           sr_2        <= '0;
                           serial_load <= 1'b1;
                           state       <= LOAD;
                        end else begin
                           word_cnt <= word_cnt + 1'b1;
                           sr_1     <= nxt_word_1;
                           sr_2     <= nxt_word_2;
                        end
                     end
                  end
               end
            end
            LOAD: begin
               if (ph_cnt != LAST_PH) begin
                  ph_cnt <= ph_cnt + 1'b1;
               end else begin
                  ph_cnt      <= '0;
                  serial_load <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= FIN;
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader: default geometry (A) and an uneven, CLK_DIV=1 geometry (B),
// each feeding a behavioural model of the two pad chains.
module tb_gpio_serial_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Instance A: NUM_IO=38, AREA1PADS=19, CLK_DIV=2 (W=19)
   logic        rst_a, start_a, busy_a, done_a, sclk_a, sload_a, sd1_a, sd2_a;
   logic [5:0]  addr1_a, addr2_a;
   logic [12:0] data1_a, data2_a;
   assign data1_a = {7'd0, addr1_a};
   assign data2_a = 13'h1000 | {7'd0, addr2_a};

   gpio_serial_loader #(.NUM_IO(38), .AREA1PADS(19), .CFG_BITS(13), .CLK_DIV(2)) dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst_a), .xfer_start(start_a), .busy(busy_a), .done(done_a),
      .cfg_addr_1(addr1_a), .cfg_data_1(data1_a), .cfg_addr_2(addr2_a), .cfg_data_2(data2_a),
      .serial_clock(sclk_a), .serial_load(sload_a), .serial_data_1(sd1_a), .serial_data_2(sd2_a));

   // Instance B: NUM_IO=38, AREA1PADS=16, CLK_DIV=1 (W=22, chain 1 gets 6 filler words)
   logic        rst_b, start_b, busy_b, done_b, sclk_b, sload_b, sd1_b, sd2_b;
   logic [5:0]  addr1_b, addr2_b;
   logic [12:0] data1_b, data2_b;
   assign data1_b = {7'd0, addr1_b};
   assign data2_b = 13'h1000 | {7'd0, addr2_b};

   gpio_serial_loader #(.NUM_IO(38), .AREA1PADS(16), .CFG_BITS(13), .CLK_DIV(1)) dut_b (
      .wb_clk_i(clk), .wb_rst_i(rst_b), .xfer_start(start_b), .busy(busy_b), .done(done_b),
      .cfg_addr_1(addr1_b), .cfg_data_1(data1_b), .cfg_addr_2(addr2_b), .cfg_data_2(data2_b),
      .serial_clock(sclk_b), .serial_load(sload_b), .serial_data_1(sd1_b), .serial_data_2(sd2_b));

   // Chain models: newest word sits in slot 0 (nearest the chain origin).
   logic [19*13-1:0] ch1_a = '0, ch2_a = '0;
   logic [22*13-1:0] ch1_b = '0, ch2_b = '0;
   logic [12:0]      pad_a [38];
   logic [12:0]      pad_b [38];

   always @(posedge sclk_a) begin
      ch1_a <= {ch1_a[19*13-2:0], sd1_a};
      ch2_a <= {ch2_a[19*13-2:0], sd2_a};
   end
   always @(posedge sclk_b) begin
      ch1_b <= {ch1_b[22*13-2:0], sd1_b};
      ch2_b <= {ch2_b[22*13-2:0], sd2_b};
   end

   int   load_cyc_a = 0, done_cnt_a = 0, load_clk_bad_a = 0, sd_bad_a = 0, done_after_load_a = 0;
   logic prev_load_a = 1'b0, prev_sd1_a = 1'b0, prev_sd2_a = 1'b0;
   int   load_cyc_b = 0, done_cnt_b = 0, sd_bad_b = 0, addr_bad_b = 0;
   logic prev_sd1_b = 1'b0, prev_sd2_b = 1'b0;

   always @(negedge clk) begin
      if (sload_a) begin
         load_cyc_a++;
         if (sclk_a) load_clk_bad_a++;
         for (int p = 0; p < 38; p++)
            pad_a[p] = (p < 19) ? ch1_a[p*13 +: 13] : ch2_a[(37-p)*13 +: 13];
      end
      if (done_a) begin
         done_cnt_a++;
         done_after_load_a = int'(prev_load_a);
      end
      if (sclk_a && (sd1_a !== prev_sd1_a || sd2_a !== prev_sd2_a)) sd_bad_a++;
      prev_load_a = sload_a;
      prev_sd1_a  = sd1_a;
      prev_sd2_a  = sd2_a;

      if (sload_b) begin
         load_cyc_b++;
         for (int p = 0; p < 38; p++)
            pad_b[p] = (p < 16) ? ch1_b[p*13 +: 13] : ch2_b[(37-p)*13 +: 13];
      end
      if (done_b) done_cnt_b++;
      if (sclk_b && (sd1_b !== prev_sd1_b || sd2_b !== prev_sd2_b)) sd_bad_b++;
      if (addr1_b > 6'd15) addr_bad_b++;
      prev_sd1_b = sd1_b;
      prev_sd2_b = sd2_b;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   int lat;

   initial begin
      for (int p = 0; p < 38; p++) begin
         pad_a[p] = 13'h1fff;
         pad_b[p] = 13'h1fff;
      end
      rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_busy",  32'(busy_a),  32'd0);
      chk("rst_done",  32'(done_a),  32'd0);
      chk("rst_sclk",  32'(sclk_a),  32'd0);
      chk("rst_sload", 32'(sload_a), 32'd0);
      chk("rst_sd1",   32'(sd1_a),   32'd0);
      chk("rst_sd2",   32'(sd2_a),   32'd0);
      chk("rst_addr1", 32'(addr1_a), 32'd0);
      chk("rst_addr2", 32'(addr2_a), 32'd0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      // Run 1 on A: extra start while busy at lat 300, and another on the FIN cycle.
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      lat = 1;
      chk("fetch_busy",  32'(busy_a),  32'd1);
      chk("fetch_addr1", 32'(addr1_a), 32'd18);
      chk("fetch_addr2", 32'(addr2_a), 32'd19);
      while (!done_a && lat < 2000) begin
         start_a = (lat == 300);
         @(negedge clk);
         lat++;
      end
      start_a = 1'b0;
      chk("a_latency", 32'(lat), 32'd992);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("fin_start_done", 32'(done_a), 32'd0);
      chk("fin_start_busy", 32'(busy_a), 32'd0);
      repeat (10) @(negedge clk);
      chk("a_no_restart",    32'(busy_a),            32'd0);
      chk("a_done_count",    32'(done_cnt_a),        32'd1);
      chk("a_load_len",      32'(load_cyc_a),        32'd2);
      chk("a_load_clk_low",  32'(load_clk_bad_a),    32'd0);
      chk("a_done_post_ld",  32'(done_after_load_a), 32'd1);
      chk("a_sd_stable",     32'(sd_bad_a),          32'd0);
      for (int i = 0; i < 38; i++)
         chk($sformatf("a_pad%0d", i), 32'(pad_a[i]), (i < 19) ? 32'(i) : 32'(13'h1000 | 13'(i)));

      // Reset at bit 100: first low-phase cycle of bit 100 is lat = 2 + 100*4.
      load_cyc_a = 0; done_cnt_a = 0;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      lat = 1;
      while (lat < 402) begin
         @(negedge clk);
         lat++;
      end
      chk("pre_rst_busy", 32'(busy_a), 32'd1);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      chk("mid_rst_busy",  32'(busy_a),  32'd0);
      chk("mid_rst_sclk",  32'(sclk_a),  32'd0);
      chk("mid_rst_sload", 32'(sload_a), 32'd0);
      chk("mid_rst_addr1", 32'(addr1_a), 32'd0);
      repeat (5) @(negedge clk);
      chk("mid_rst_noload", 32'(load_cyc_a), 32'd0);
      chk("mid_rst_nodone", 32'(done_cnt_a), 32'd0);

      // Start coincident with reset is dropped.
      rst_a = 1'b1; start_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0; start_a = 1'b0;
      chk("rst_start_busy", 32'(busy_a), 32'd0);
      repeat (3) @(negedge clk);
      chk("rst_start_idle", 32'(busy_a), 32'd0);

      // Fresh transfer after the aborted one.
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      lat = 1;
      while (!done_a && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      chk("a2_latency",  32'(lat),        32'd992);
      chk("a2_load_len", 32'(load_cyc_a), 32'd2);
      chk("a2_pad5",     32'(pad_a[5]),   32'd5);
      chk("a2_pad30",    32'(pad_a[30]),  32'h101e);

      // Instance B: uneven chains, CLK_DIV=1.
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      lat = 1;
      chk("b_fetch_addr1", 32'(addr1_b), 32'd0);
      chk("b_fetch_addr2", 32'(addr2_b), 32'd16);
      while (!done_b && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      chk("b_latency",   32'(lat),        32'd575);
      repeat (3) @(negedge clk);
      chk("b_done_count", 32'(done_cnt_b), 32'd1);
      chk("b_load_len",   32'(load_cyc_b), 32'd1);
      chk("b_sd_stable",  32'(sd_bad_b),   32'd0);
      chk("b_addr1_range", 32'(addr_bad_b), 32'd0);
      for (int i = 0; i < 38; i++)
         chk($sformatf("b_pad%0d", i), 32'(pad_b[i]), (i < 16) ? 32'(i) : 32'(13'h1000 | 13'(i)));
      for (int s = 16; s < 22; s++)
         chk($sformatf("b_filler%0d", s), 32'(ch1_b[s*13 +: 13]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
